// File: rtl/dot_pkg.sv
// dot_pkg: shared FSM states, default sizes and accumulator width for dot_product_mac
package dot_pkg;
  typedef enum logic [1:0] {IDLE, REQ, ACCUM, DONE} state_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_VECTOR_WIDTH = 4;
  function automatic int acc_w(input int dw, input int vw);
    return 2 * dw + $clog2(vw);
  endfunction
endpackage

// File: rtl/mac_unit.sv
// mac_unit: multiply and registered accumulate; DOT_SIGNED_EN selects two's complement operands
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);
  logic [ACC_WIDTH-1:0] acc_q, prod_x;
`ifdef DOT_SIGNED_EN
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = $signed({{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i}) * $signed({{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i});
  assign prod_x = ACC_WIDTH'(prod);
`else
  logic [2*DATA_WIDTH-1:0] prod;
  assign prod = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
  assign prod_x = ACC_WIDTH'(prod);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i) acc_q <= acc_q + prod_x;
  assign acc_o = acc_q;
endmodule

// File: rtl/dot_product_mac.sv
// dot_product_mac: one dot product per requested vector from the paired reader stream (DOT_SIGNED_EN: signed math)
module dot_product_mac
  import dot_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int ACC_WIDTH    = acc_w(DATA_WIDTH, VECTOR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  start_reading,
  input  logic                  reading_done,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  in_valid,
  input  logic [2:0]            in_count,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  seq_err
);
  localparam logic [2:0] LAST = 3'(VECTOR_WIDTH - 1);
  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 err_q, err_d, clr, en, last;
  logic [ACC_WIDTH-1:0] result_q, result_d, acc;
  mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(en), .a_i(a_in), .b_i(b_in), .acc_o(acc)
  );
  assign last = in_valid && cnt_q == LAST;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    clr      = 1'b0;
    en       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        clr     = 1'b1;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = REQ;
      end
      REQ: state_d = ACCUM;
      ACCUM: begin
        en = in_valid;
        if (in_valid) begin
          cnt_d = cnt_q + 3'd1;
          if (in_count != cnt_q) err_d = 1'b1;
        end
        // a final element arriving with reading_done is a normal completion
        if (last) state_d = DONE;
        else if (reading_done) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        result_d = acc;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  // the accumulator already holds the final sum in DONE, so expose it alongside the valid pulse
  assign result        = state_q == DONE ? acc : result_q;
  assign result_valid  = state_q == DONE;
  assign start_reading = state_q == REQ;
  assign busy          = state_q != IDLE;
  assign seq_err       = err_q;
endmodule

// File: tb/tb_dot_product_mac.sv
// tb_dot_product_mac: scoreboard bench for dot_product_mac (DOT_SIGNED_EN selects the signed vectors)
module tb_dot_product_mac;
  localparam int AW = 18;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, reading_done = 1'b0, in_valid = 1'b0;
  logic [7:0]    a_in = '0, b_in = '0;
  logic [2:0]    in_count = '0;
  logic          start_reading, result_valid, busy, seq_err;
  logic [AW-1:0] result;
  int            n_cmp = 0, n_bad = 0, sr_seen = 0, sr_exp = 0;
  int            va[4], vb[4], vc[4];
  logic [AW:0]   sb_q[$];

  dot_product_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_reading(start_reading),
    .reading_done(reading_done), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_count(in_count), .result(result), .result_valid(result_valid),
    .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [AW:0] e;
    if (start_reading) sr_seen++;
    if (result_valid) begin
      if (sb_q.size() == 0) check("spurious_rv", 32'(result_valid), 32'd0);
      else begin
        e = sb_q.pop_front();
        check("result", 32'(result), 32'(e[AW-1:0]));
        check("seq_err", 32'(seq_err), 32'(e[AW]));
      end
    end
  end

  task automatic run_vec(input int n, input bit early, input bit poke);
    int                 sum = 0;
    bit                 err = early;
    logic signed [7:0]  sa, sb;
    logic [AW-1:0]      r;
    for (int i = 0; i < n; i++) begin
      sa = va[i][7:0];
      sb = vb[i][7:0];
`ifdef DOT_SIGNED_EN
      sum += int'(sa) * int'(sb);
`else
      sum += int'({24'd0, sa}) * int'({24'd0, sb});
`endif
      if (vc[i] != i) err = 1'b1;
    end
    r = AW'(sum);
    @(posedge clk); #1 start = 1'b1;
    sb_q.push_back({err, r});
    sr_exp++;
    @(posedge clk); #1 start = 1'b0;
    check("start_reading", 32'(start_reading), 32'd1);
    check("seq_err_clr", 32'(seq_err), 32'd0);
    check("busy", 32'(busy), 32'd1);
    @(posedge clk); #1 check("sr_pulse", 32'(start_reading), 32'd0);
    for (int i = 0; i < n; i++) begin
      in_valid     = 1'b1;
      a_in         = va[i][7:0];
      b_in         = vb[i][7:0];
      in_count     = vc[i][2:0];
      reading_done = !early && i == n - 1;
      start        = poke && i == 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; reading_done = 1'b0; start = 1'b0;
    if (early) begin
      check("early_no_rv", 32'(result_valid), 32'd0);
      reading_done = 1'b1;
      @(posedge clk); #1 reading_done = 1'b0;
    end
    check("rv_latency", 32'(result_valid), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_err", 32'(seq_err), 32'd0);
    rst_n = 1'b1;
    vc = '{0, 1, 2, 3};
`ifdef DOT_SIGNED_EN
    va = '{-1, 2, -3, 4}; vb = '{5, 6, 7, 8};
    run_vec(4, 0, 0);
    va = '{-128, -128, -128, -128}; vb = va;
    run_vec(4, 0, 0);
    va = '{-1, 2, -3, 4}; vb = '{5, 6, 7, 8};
`else
    va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8};
    run_vec(4, 0, 0);
    va = '{255, 255, 255, 255}; vb = va;
    run_vec(4, 0, 0);
    va = '{1, 1, 1, 1}; vb = va;
    run_vec(4, 0, 0);
    va = '{2, 3, 0, 0}; vb = '{4, 5, 0, 0};
    run_vec(2, 1, 0);
    va = '{1, 2, 3, 4}; vb = '{1, 1, 1, 1}; vc = '{0, 1, 1, 3};
    run_vec(4, 0, 1);
    vc = '{0, 1, 2, 3};
    va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8};
`endif
    @(posedge clk); #1 start = 1'b1;
    sr_exp++;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a_in = va[i][7:0]; b_in = vb[i][7:0]; in_count = 3'(i);
      if (i < 2) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1 check("arst_result", 32'(result), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sr", 32'(start_reading), 32'd0);
    check("arst_rv", 32'(result_valid), 32'd0);
    check("arst_err", 32'(seq_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(4, 0, 0);
    repeat (3) @(posedge clk);
    #1 check("sr_count", 32'(sr_seen), 32'(sr_exp));
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dot_product_mac.md
Name: dot_product_mac

Overview:
- Downstream of `memory_reader_wrapper`. Consumes the paired element stream `mem1_output`/`mem2_output`/`data_valid`/`element_count`/`reading_done` and computes one dot product per vector.
- Owns the `start_reading` request toward the reader.
- Presents a registered result with a one-cycle valid pulse to the next stage (result register / host).

Parameters:
- DATA_WIDTH, 8, operand width of each element.
- VECTOR_WIDTH, 4, elements per vector; legal range 1..7 (3-bit element index).
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(VECTOR_WIDTH) (=18), accumulator and result width; never overflows.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request one dot product; sampled only in IDLE.
- start_reading  output  1  one-cycle pulse to reader's start_reading.
- reading_done  input  1  reader finished the vector.
- a_in  input  DATA_WIDTH  element from mem1_output.
- b_in  input  DATA_WIDTH  element from mem2_output.
- in_valid  input  1  a_in/b_in valid (reader data_valid).
- in_count  input  3  reader element_count, 0-based index of current element.
- result  output  ACC_WIDTH  dot product; held until next start.
- result_valid  output  1  one-cycle pulse when result updates.
- busy  output  1  high in any state except IDLE.
- seq_err  output  1  sticky sequence error; cleared on accepted start.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: all outputs 0, accumulator 0, element counter 0, state IDLE. Reset mid-operation aborts immediately. No result_valid is produced for the aborted vector.
- States: IDLE, REQ, ACCUM, DONE.
- IDLE:
  - start=1 → clear accumulator, element counter and seq_err; go to REQ.
  - start while busy is ignored, with no queueing.
- REQ:
  - start_reading=1 for exactly this one cycle; go to ACCUM.
- ACCUM, per element:
  - Each cycle with in_valid=1: acc <= acc + a_in*b_in and the counter increments.
  - If in_count != counter value, set seq_err; the product is still accumulated.
- ACCUM, completion:
  - When the VECTOR_WIDTH-th valid element is accepted, go to DONE.
  - reading_done in the same cycle as the final element: element counts and the normal completion path is taken.
  - reading_done before VECTOR_WIDTH elements: set seq_err and go to DONE with the partial sum.
- DONE:
  - result <= acc; result_valid=1 for one cycle; return to IDLE.
  - Latency: result_valid one cycle after the last accepted in_valid (two cycles when reading_done ends early).
- in_valid outside ACCUM is ignored and does not affect acc.
- Arithmetic (default): unsigned. Product is 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH.
- result holds its value through IDLE and only changes in DONE.
- Minimum back-to-back spacing: start may be accepted in the cycle after DONE.

Optional Feature:
- Macro: DOT_SIGNED_EN.
- Defined: operands are two's complement. Product and accumulation are signed, sign-extended to ACC_WIDTH, and result is signed.
- Undefined: unsigned arithmetic as above.
- Port list is identical in both builds.

Decomposition:
- Package `dot_pkg`:
  - State enum (IDLE/REQ/ACCUM/DONE).
  - Default DATA_WIDTH/VECTOR_WIDTH constants.
  - ACC_WIDTH derivation function.
- Sub-module `mac_unit`:
  - Combinational multiply plus registered accumulate, with clear and enable inputs.
  - Contains all DOT_SIGNED_EN handling.
- FSM, counter and error logic stay in the top module.

Test Plan:
1. Reset mid-ACCUM: assert rst_n=0 after 2 elements → all outputs 0 asynchronously, no result_valid, state IDLE. Next vector computes correctly.
2. Basic vector (unsigned): a=[1,2,3,4], b=[5,6,7,8] with in_count 0..3 → start_reading one pulse after start; result=70, result_valid one cycle after 4th in_valid, seq_err=0.
3. Max values: all a=b=255 → result=260100 with no overflow. Back-to-back second vector a=b=[1,1,1,1] started the cycle after result_valid → result=4.
4. Early termination: reading_done after 2 elements (a=[2,3], b=[4,5]) → result=23, seq_err=1. The next accepted start clears seq_err.
5. Index mismatch plus ignored start: in_count sequence 0,1,1,3 → seq_err=1, result still the full sum. start pulses while busy → no extra start_reading.
6. DOT_SIGNED_EN build: a=[-1,2,-3,4], b=[5,6,7,8] → result=18. a=b=[-128 ×4] → result=65536.
